// File: rtl/attn_stream_loader.sv
// Streams K/Q/V words into the 8x8 attention core's flat buses, runs one job, streams the result back.
// Optional RUN watchdog: define ATTN_LOADER_TIMEOUT_EN.
module attn_stream_loader #(
    parameter int DATA_W         = 16,
    parameter int IN_WORDS       = 96,
    parameter int OUT_WORDS      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              core_en,
    output logic [511:0]      core_key,
    output logic [511:0]      core_query,
    output logic [511:0]      core_value,
    input  logic [511:0]      core_final_res,
    input  logic              core_all_done,
    output logic              busy,
    output logic              err
);

    // Both streams use valid/ready: a word moves on a rising edge where valid and ready are
    // both high; valid never waits on ready, and data is held while valid is high and ready low.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam logic [6:0] IN_LAST  = 7'(IN_WORDS - 1);
    localparam logic [4:0] OUT_LAST = 5'(OUT_WORDS - 1);

    state_e       state_q, state_d;
    logic [6:0]   in_cnt_q, in_cnt_d;
    logic [4:0]   out_cnt_q, out_cnt_d;
    logic [511:0] key_q, key_d;
    logic [511:0] query_q, query_d;
    logic [511:0] value_q, value_d;
    logic [511:0] res_q, res_d;
    logic         err_q, err_d;
    logic         rdy_arm_q, rdy_arm_d;

    logic         s_hs;
    logic         m_hs;
    logic         tmo_hit;
    logic [8:0]   wr_base;
    logic [8:0]   rd_base;

    assign s_hs    = s_valid & s_ready;
    assign m_hs    = m_valid & m_ready;
    assign wr_base = {in_cnt_q[4:0], 4'b0000};
    assign rd_base = {out_cnt_q, 4'b0000};

`ifdef ATTN_LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ST_RUN && tmo_cnt_q != TMO_LAST) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Completion in the final cycle wins over the watchdog.
    assign tmo_hit = (state_q == ST_RUN) && !core_all_done && (tmo_cnt_q == TMO_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (s_hs) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (s_hs && in_cnt_q == IN_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (core_all_done) state_d = ST_DRAIN;
                else if (tmo_hit) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (m_hs && out_cnt_q == OUT_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        s_ready = rdy_arm_q && (state_q == ST_IDLE || state_q == ST_LOAD);
        core_en = (state_q == ST_RUN);
        m_valid = (state_q == ST_DRAIN);
        m_last  = (state_q == ST_DRAIN) && (out_cnt_q == OUT_LAST);
        busy    = (state_q != ST_IDLE);
        m_data  = res_q[rd_base +: 16];
    end

    assign core_key   = key_q;
    assign core_query = query_q;
    assign core_value = value_q;
    assign err        = err_q;

    // ---------------- datapath ----------------
    always_comb begin
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        key_d     = key_q;
        query_d   = query_q;
        value_d   = value_q;
        res_d     = res_q;
        err_d     = err_q;
        rdy_arm_d = 1'b1;

        // Count 0 in IDLE doubles as the slot for word 0, so IDLE and LOAD share this path.
        if (s_hs) begin
            unique case (in_cnt_q[6:5])
                2'd0:    key_d[wr_base +: 16]   = s_data;
                2'd1:    query_d[wr_base +: 16] = s_data;
                default: value_d[wr_base +: 16] = s_data;
            endcase
            in_cnt_d = (in_cnt_q == IN_LAST) ? 7'd0 : in_cnt_q + 7'd1;
            if (state_q == ST_IDLE) err_d = 1'b0;
        end

        if (state_q == ST_RUN && core_all_done) begin
            res_d = core_final_res;
        end

        if (tmo_hit) begin
            err_d = 1'b1;
        end

        if (m_hs) begin
            out_cnt_d = (out_cnt_q == OUT_LAST) ? 5'd0 : out_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            key_q     <= '0;
            query_q   <= '0;
            value_q   <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            rdy_arm_q <= 1'b0;
        end else begin
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            key_q     <= key_d;
            query_q   <= query_d;
            value_q   <= value_d;
            res_q     <= res_d;
            err_q     <= err_d;
            rdy_arm_q <= rdy_arm_d;
        end
    end

endmodule

// File: tb/tb_attn_stream_loader.sv
// Randomized bench for attn_stream_loader: drives the input stream, stands in for the core,
// and checks packing, handshake timing and the result stream against a word-level model.
module tb_attn_stream_loader;

    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [15:0]  m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic         m_last;
    logic         core_en;
    logic [511:0] core_key, core_query, core_value;
    logic [511:0] core_final_res = '0;
    logic         core_all_done = 1'b0;
    logic         busy;
    logic         err;

    logic [15:0]  words [96];
    logic [15:0]  exp_q [$];
    int           n_checks = 0;
    int           n_err = 0;

    attn_stream_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .core_en(core_en), .core_key(core_key), .core_query(core_query), .core_value(core_value),
        .core_final_res(core_final_res), .core_all_done(core_all_done),
        .busy(busy), .err(err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [511:0] pack(input int base);
        logic [511:0] r;
        r = '0;
        for (int w = 0; w < 32; w++) r[w*16 +: 16] = words[base + w];
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic fill_words(input bit counting);
        for (int i = 0; i < 96; i++) words[i] = counting ? 16'(i + 1) : 16'($urandom);
    endtask

    // Offers words[0..n-1]; a word counts as sent only on a cycle where ready is high.
    task automatic send_words(input int n, input int gap_pct);
        int k;
        int budget;
        k = 0;
        budget = 0;
        while (k < n && budget < 3000) begin
            @(negedge clk);
            budget++;
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data  = s_valid ? words[k] : 16'($urandom);
            if (s_valid && s_ready) begin
                if (k == 95) check("core_en_before_last", {511'd0, core_en}, 512'd0);
                k++;
            end
        end
        if (k < n) check("load_budget", 512'(k), 512'(n));
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic load_job(input int gap_pct);
        send_words(96, gap_pct);
        check("run_core_en", {511'd0, core_en}, 512'd1);
        check("run_s_ready", {511'd0, s_ready}, 512'd0);
        check("run_busy", {511'd0, busy}, 512'd1);
        check("key_bus", core_key, pack(0));
        check("query_bus", core_query, pack(32));
        check("value_bus", core_value, pack(64));
    endtask

    // Stand-in for the core: all_done after `delay` enabled cycles; called one cycle into RUN.
    task automatic run_core(input int delay, input bit counting);
        logic [511:0] res;
        for (int j = 0; j < 32; j++) res[j*16 +: 16] = counting ? 16'(16'hA000 + j) : 16'($urandom);
        for (int j = 0; j < 32; j++) exp_q.push_back(res[j*16 +: 16]);
        for (int c = 1; c < delay; c++) begin
            @(negedge clk);
            if (c == delay - 1) check("wait_core_en", {511'd0, core_en}, 512'd1);
            if (c == delay - 1) check("wait_m_valid", {511'd0, m_valid}, 512'd0);
        end
        core_final_res = res;
        core_all_done  = 1'b1;
        @(negedge clk);
        core_all_done  = 1'b0;
        core_final_res = {16{32'($urandom)}};
        check("done_core_en", {511'd0, core_en}, 512'd0);
        check("done_m_valid", {511'd0, m_valid}, 512'd1);
    endtask

    task automatic drain(input int stall_pct);
        int budget;
        budget = 0;
        while (exp_q.size() > 0 && budget < 3000) begin
            budget++;
            check("drain_m_valid", {511'd0, m_valid}, 512'd1);
            check("drain_s_ready", {511'd0, s_ready}, 512'd0);
            check("drain_m_data", {496'd0, m_data}, {496'd0, exp_q[0]});
            check("drain_m_last", {511'd0, m_last}, {511'd0, exp_q.size() == 1});
            m_ready = ($urandom_range(99) >= stall_pct);
            if (m_ready && m_valid) void'(exp_q.pop_front());
            @(negedge clk);
        end
        if (exp_q.size() != 0) check("drain_budget", 512'(exp_q.size()), 512'd0);
        exp_q.delete();
        m_ready = 1'b0;
        check("end_m_valid", {511'd0, m_valid}, 512'd0);
        check("end_busy", {511'd0, busy}, 512'd0);
        check("end_s_ready", {511'd0, s_ready}, 512'd1);
        check("end_core_en", {511'd0, core_en}, 512'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, {511'd0, s_ready}, 512'd0);
        check({tag, "_m_valid"}, {511'd0, m_valid}, 512'd0);
        check({tag, "_m_last"}, {511'd0, m_last}, 512'd0);
        check({tag, "_core_en"}, {511'd0, core_en}, 512'd0);
        check({tag, "_busy"}, {511'd0, busy}, 512'd0);
        check({tag, "_err"}, {511'd0, err}, 512'd0);
        check({tag, "_key"}, core_key, 512'd0);
        check({tag, "_query"}, core_query, 512'd0);
        check({tag, "_value"}, core_value, 512'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Reset asserted from time 0, then released; then pulsed again mid-idle.
        repeat (3) @(negedge clk);
        check_all_zero("por");
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_idle");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_s_ready", {511'd0, s_ready}, 512'd1);
        check("rel_busy", {511'd0, busy}, 512'd0);

        // all_done outside RUN must not start a drain.
        core_all_done = 1'b1;
        repeat (3) @(negedge clk);
        core_all_done = 1'b0;
        check("idle_done_m_valid", {511'd0, m_valid}, 512'd0);
        check("idle_done_busy", {511'd0, busy}, 512'd0);

        // Counting stream back-to-back, fixed-pattern result.
        fill_words(1'b1);
        load_job(0);
        check("key_w0", {496'd0, core_key[15:0]}, 512'h0001);
        check("key_w31", {496'd0, core_key[511:496]}, 512'h0020);
        check("query_w0", {496'd0, core_query[15:0]}, 512'h0021);
        check("value_w31", {496'd0, core_value[511:496]}, 512'h0060);
        run_core(10, 1'b1);
        drain(40);

        // Same stream with 50% bubbles.
        load_job(50);
        run_core(3, 1'b1);
        drain(0);

        // Reset in the middle of loading.
        fill_words(1'b0);
        send_words(40, 20);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_load_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_job(30);
        run_core(1 + $urandom_range(15), 1'b0);
        drain(50);

        // Random jobs.
        for (int t = 0; t < 4; t++) begin
            fill_words(1'b0);
            load_job($urandom_range(60));
            run_core(1 + $urandom_range(20), 1'b0);
            drain($urandom_range(70));
        end

        // Core never completes.
        fill_words(1'b0);
        load_job(10);
`ifdef ATTN_LOADER_TIMEOUT_EN
        repeat (TMO - 1) @(negedge clk);
        check("tmo_last_core_en", {511'd0, core_en}, 512'd1);
        check("tmo_last_err", {511'd0, err}, 512'd0);
        @(negedge clk);
        check("tmo_core_en", {511'd0, core_en}, 512'd0);
        check("tmo_err", {511'd0, err}, 512'd1);
        check("tmo_busy", {511'd0, busy}, 512'd0);
        check("tmo_m_valid", {511'd0, m_valid}, 512'd0);
        repeat (5) @(negedge clk);
        check("tmo_err_sticky", {511'd0, err}, 512'd1);
        check("tmo_no_m_valid", {511'd0, m_valid}, 512'd0);
        fill_words(1'b0);
        load_job(0);
        check("tmo_err_cleared", {511'd0, err}, 512'd0);
        run_core(4, 1'b0);
        drain(20);
`else
        repeat (199) @(negedge clk);
        check("hang_core_en", {511'd0, core_en}, 512'd1);
        check("hang_busy", {511'd0, busy}, 512'd1);
        check("hang_m_valid", {511'd0, m_valid}, 512'd0);
        check("hang_err", {511'd0, err}, 512'd0);
        run_core(1, 1'b0);
        drain(20);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
